// File: rtl/dsp48e1_pkg.sv
// Shared widths and INMODE bit positions for the DSP pre-adder slice.
package dsp48e1_pkg;

   localparam int A_W      = 30;
   localparam int AMULT_W  = 25;
   localparam int D_W      = 25;
   localparam int INMODE_W = 4;

   // INMODE bit positions
   localparam int IM_A1_SEL = 0;   // 1: multiplier A from A1, 0: from A2
   localparam int IM_A_ZERO = 1;   // 1: force multiplier-side A to zero
   localparam int IM_D_EN   = 2;   // 1: D term participates
   localparam int IM_SUB    = 3;   // 1: D - A instead of D + A

   typedef logic [INMODE_W-1:0] inmode_t;

   // Pipeline depth from a_in/d_in to a_mult with every CE held high.
   function automatic int preadd_latency(input int areg, input int dreg, input int adreg);
      return ((areg > dreg) ? areg : dreg) + adreg;
   endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Single optional pipeline register: DEPTH=0 is a wire, DEPTH=1 is a
// CE-gated flop with asynchronous active-low clear.
module dsp_pipe_reg #(
   parameter int W     = 25,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rst_n, ce};
         assign q = d;
      end else begin : g_reg
         logic [W-1:0] q_r;
         // Load on CE, hold otherwise; clear is independent of CE.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q_r <= '0;
            end else if (ce) begin
               q_r <= d;
            end
         end
         assign q = q_r;
      end
   endgenerate

endmodule

// File: rtl/dsp_preadd_stage.sv
// DSP48-style A/D input registers and pre-adder feeding the multiplier A port.
// Build option: define DSP_PREADD_SUB_EN to let inmode[3] select D - A;
// without it the pre-adder only adds and inmode[3] is ignored.
module dsp_preadd_stage
   import dsp48e1_pkg::*;
#(
   parameter int AREG  = 1,
   parameter int DREG  = 1,
   parameter int ADREG = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [A_W-1:0]     a_in,
   input  logic [D_W-1:0]     d_in,
   input  logic               cea1,
   input  logic               cea2,
   input  logic               ced,
   input  logic               cead,
   input  logic [INMODE_W-1:0] inmode,
   input  logic               valid_in,
   output logic [AMULT_W-1:0] a_mult,
   output logic [A_W-1:0]     a_out,
   output logic               valid_out
);

   localparam int LAT = preadd_latency(AREG, DREG, ADREG);

   generate
      if (AREG < 0 || AREG > 2) begin : g_bad_areg
         $error("dsp_preadd_stage: AREG must be 0, 1 or 2");
      end
      if (DREG < 0 || DREG > 1) begin : g_bad_dreg
         $error("dsp_preadd_stage: DREG must be 0 or 1");
      end
      if (ADREG < 0 || ADREG > 1) begin : g_bad_adreg
         $error("dsp_preadd_stage: ADREG must be 0 or 1");
      end
   endgenerate

   logic [A_W-1:0]     a1_q;
   logic [A_W-1:0]     a2_q;
   logic [D_W-1:0]     d_q;
   logic [AMULT_W-1:0] a_sel;
   logic [D_W-1:0]     d_term;
   logic [AMULT_W-1:0] ad_d;

   // A1 only exists for AREG=2; when bypassed a1_q is a_in, so A2 can
   // always take its input from a1_q.
   dsp_pipe_reg #(.W(A_W), .DEPTH((AREG == 2) ? 1 : 0)) u_a1 (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (cea1),
      .d     (a_in),
      .q     (a1_q)
   );

   dsp_pipe_reg #(.W(A_W), .DEPTH((AREG >= 1) ? 1 : 0)) u_a2 (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (cea2),
      .d     (a1_q),
      .q     (a2_q)
   );

   dsp_pipe_reg #(.W(D_W), .DEPTH(DREG)) u_d (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ced),
      .d     (d_in),
      .q     (d_q)
   );

   assign a_out = a2_q;

   // Multiplier-side A select and D gating; inmode acts on the operands
   // currently leaving the input registers.
   always_comb begin
      a_sel  = a2_q[AMULT_W-1:0];
      d_term = '0;
      if (AREG == 2 && inmode[IM_A1_SEL]) begin
         a_sel = a1_q[AMULT_W-1:0];
      end
      if (inmode[IM_A_ZERO]) begin
         a_sel = '0;
      end
      if (inmode[IM_D_EN]) begin
         d_term = d_q;
      end
   end

`ifdef DSP_PREADD_SUB_EN
   // Pre-adder, wraps modulo 2^25.
   always_comb begin
      ad_d = d_term + a_sel;
      if (inmode[IM_SUB]) begin
         ad_d = d_term - a_sel;
      end
   end
`else
   logic unused_sub;
   assign unused_sub = inmode[IM_SUB];

   // Pre-adder, add only, wraps modulo 2^25.
   always_comb begin
      ad_d = d_term + a_sel;
   end
`endif

   dsp_pipe_reg #(.W(AMULT_W), .DEPTH(ADREG)) u_ad (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (cead),
      .d     (ad_d),
      .q     (a_mult)
   );

   // valid_in follows the nominal latency and ignores every CE.
   generate
      if (LAT == 0) begin : g_vbypass
         assign valid_out = valid_in;
      end else begin : g_vpipe
         logic [LAT-1:0] vsr;
         // Free-running valid shift register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vsr <= '0;
            end else begin
               vsr[0] <= valid_in;
               for (int i = 1; i < LAT; i++) begin
                  vsr[i] <= vsr[i-1];
               end
            end
         end
         assign valid_out = vsr[LAT-1];
      end
   endgenerate

endmodule

// File: doc/dsp_preadd_stage.md
DSP_PREADD_STAGE -- requirements
Module: dsp_preadd_stage

Interface
REQ-001 Parameter AREG, default 1: number of A input registers (0, 1 or 2).
REQ-002 Parameter DREG, default 1: number of D input registers (0 or 1).
REQ-003 Parameter ADREG, default 1: number of pre-adder output registers (0 or 1).
REQ-004 clk  input  1: single clock; all registers update on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 a_in  input  30: A operand; bits [24:0] feed the pre-adder.
REQ-007 d_in  input  25: D operand, two's complement.
REQ-008 cea1, cea2, ced, cead  input  1 each: clock enables for the A1, A2, D and AD registers.
REQ-009 inmode  input  4: [0] selects A1 (1) or A2 (0), [1] forces A to zero, [2] enables D, [3] selects subtract.
REQ-010 valid_in  input  1: input sample qualifier.
REQ-011 a_mult  output  25: pre-adder result that drives the 25-bit multiplier A port.
REQ-012 a_out  output  30: final A register output, used for the downstream A:B concatenation.
REQ-013 valid_out  output  1: valid_in delayed to match a_mult.

Function
REQ-014 A path: AREG=0 is combinational; AREG=1 uses A2 only; AREG=2 uses A1 followed by A2. Each register loads only when its CE is 1.
REQ-015 Multiplier-side A: A1 when AREG=2 and inmode[0]=1, otherwise the last A stage. Forced to 0 when inmode[1]=1.
REQ-016 D path: DREG=1 registers d_in under ced. The D term is 0 when inmode[2]=0.
REQ-017 Pre-adder computes D + A, or D - A when inmode[3]=1. Both operands are 25-bit two's complement, and the result wraps modulo 2^25 with no saturation and no overflow flag.
REQ-018 ADREG=1 registers the pre-adder result under cead; ADREG=0 drives a_mult combinationally.
REQ-019 inmode is not registered; it is applied on the cycle the pre-adder operands are presented.
REQ-020 a_out equals the A2 output, or a_in when AREG=0; it is unaffected by inmode.
REQ-021 Latency from a_in/d_in to a_mult with all CEs at 1 is LAT = max(AREG, DREG) + ADREG cycles.
REQ-022 valid_out is valid_in through a free-running LAT-deep shift register. It is independent of the CEs.
REQ-023 A register with CE=0 holds its value, including while other stages advance.
REQ-024 Illegal parameter values (AREG>2, DREG>1, ADREG>1) produce an elaboration error.

Reset
REQ-025 rst_n=0 asynchronously clears A1, A2, D, AD and the valid pipeline to 0, regardless of CEs.
REQ-026 During and immediately after reset: registered a_mult = 0, a_out = 0, valid_out = 0.
REQ-027 Reset asserted mid-operation discards all in-flight samples; no stale valid_out appears after release.

Configuration
REQ-028 Macro DSP_PREADD_SUB_EN defined: inmode[3] selects subtract per REQ-017.
REQ-029 Macro DSP_PREADD_SUB_EN undefined: inmode[3] is ignored, the pre-adder always adds, and the subtract logic is absent.

Structure
REQ-030 Package dsp48e1_pkg holds the width constants A_W=30, AMULT_W=25 and D_W=25, plus the inmode bit-index constants.
REQ-031 Sub-module dsp_pipe_reg: parameterised width, bypassable when depth is 0, with CE and asynchronous active-low clear. It is instantiated for A1, A2, D and AD.

Verification (AREG=1, DREG=1, ADREG=1 unless stated)
REQ-032 Add: d=100, a=30, inmode=4'b0100, all CEs=1 -> a_mult=130 and valid_out=1 exactly 2 cycles after the inputs are applied.
REQ-033 Subtract (macro defined): d=100, a=30, inmode=4'b1100 -> a_mult=70. Macro undefined: same stimulus -> a_mult=130.
REQ-034 Wrap: d=25'h0FFFFFF, a=1, add -> a_mult=25'h1000000. Also d=0, a=0, subtract, with inmode[1]=1 -> a_mult=0.
REQ-035 Register select, AREG=2: a=5 then a=9 on consecutive cycles with inmode[0] toggled -> A1 presents 9 while A2 presents 5. Setting inmode[2]=0 -> a_mult equals the selected A value.
REQ-036 CE hold and reset: cead=0 for 3 cycles -> a_mult frozen. rst_n low mid-stream -> a_mult, a_out and valid_out are 0 within the same cycle, with no valid_out for 2 cycles after release.
